// File: rtl/mips_pkg.sv
// Shared constants and the fetch FSM state type for the MIPS-style front end.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Sequential successor; wraps naturally at 2^32.
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_ifid_reg.sv
// IF/ID pipeline register: valid/ready holding stage for instr, pc and pc+4, with flush.
module ifid_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_load,
  input  logic               i_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [PC_W-1:0]    i_pc4,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc4
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc4;

  // Flush outranks load; an unreplaced entry drains once decode takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, ROM addressing, fetch FSM and IF/ID hand-off to decode.
// Optional IFETCH_MISALIGN_EN: misaligned redirects halt fetch and raise sticky fetch_err.
module inst_fetch
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_sel,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc4,
  output logic               halted
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic               fetch_err
`endif
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc4;
  logic [PC_W-1:0] w_redir_target;
  logic            w_redir_req;
  logic            w_misalign;
  logic            w_redir_take;
  logic            w_redir_fault;
  logic            w_load;
  logic            w_if_valid;

  assign w_pc4          = pc_plus4(r_pc);
  assign w_redir_target = redirect_pc & ~32'h0000_0003;
  // BOOT ignores redirects entirely, so they neither flush nor retarget.
  assign w_redir_req    = redirect_valid && (r_state != BOOT);

`ifdef IFETCH_MISALIGN_EN
  assign w_misalign = |redirect_pc[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_redir_take  = w_redir_req && !w_misalign;
  assign w_redir_fault = w_redir_req && w_misalign;

  assign w_load = (r_state == RUN) && !halt_req && !redirect_valid &&
                  (!w_if_valid || id_ready);

  assign rom_addr = r_pc[ADDR_W+1:2];
  assign rom_sel  = w_load;
  assign halted   = (r_state == HALT);
  assign if_valid = w_if_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        if (w_redir_fault) begin
          w_state_next = HALT;
        end else if (w_redir_take) begin
          w_state_next = RUN;
          w_pc_next    = w_redir_target;
        end else if (halt_req) begin
          w_state_next = HALT;
        end else if (w_load) begin
          w_pc_next = w_pc4;
        end
      end
      HALT: begin
        if (w_redir_take) begin
          w_state_next = RUN;
          w_pc_next    = w_redir_target;
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

`ifdef IFETCH_MISALIGN_EN
  logic r_fetch_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_err <= 1'b0;
    end else if (w_redir_fault) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`endif

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_redir_req),
    .i_load  (w_load),
    .i_ready (id_ready),
    .i_instr (rom_data),
    .i_pc    (r_pc),
    .i_pc4   (w_pc4),
    .o_valid (w_if_valid),
    .o_instr (if_instr),
    .o_pc    (if_pc),
    .o_pc4   (if_pc4)
  );

endmodule
